instr_fetch: RTL and testbench

Instruction fetch unit: the requesting end of the instruction-memory interface. It owns the fetch PC, drives `a_instr` into `instr_mem`, and captures the combinational `rd_instr` return into a small prefetch queue. The queue feeds the decode stage through a valid/ready handshake. Branch/jump redirects from execute flush the queue and restart fetch.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 75 +++++++
 rtl/instr_fetch.sv | 90 +++++++++
 tb/tb_instr_fetch.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: word widths, the canonical NOP, and
// the {pc, instr} pair carried through the fetch queue.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] INSTR_BYTES      = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Instruction addresses are word aligned; the low two bits never carry meaning.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO of {pc, instr} entries. Flush wins over push and
// pop; a push is accepted on a full queue only when a pop frees a slot.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               push,
  input  logic               pop,
  input  fetch_entry_t       din,
  output fetch_entry_t       dout,
  output logic               full,
  output logic               empty,
  output logic [CNT_W-1:0]   count
);

  fetch_entry_t     mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_reg == '0);
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign count = count_reg;

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the wrap.
      if (do_push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (do_pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is not reset: contents are meaningless whenever count is zero.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= din;
  end

  assign dout = mem_reg[rd_ptr_reg];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the fetch PC, captures instr_mem returns into a
// prefetch queue and hands them to decode over a valid/ready handshake.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] a_instr,
  input  logic [XLEN-1:0] rd_instr,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  fetch_pc_reg, fetch_pc_next;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             do_push;
  logic             do_pop;

  // A redirect kills both sides of the queue in the same cycle, including a
  // head that decode was about to accept.
  assign do_pop  = out_valid && out_ready && !redirect_valid;
  assign do_push = fetch_en && !redirect_valid && (!fifo_full || do_pop);

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = fetch_pc_reg;
    push_entry.instr = rd_instr;
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect_valid) begin
      fetch_pc_next = align_pc(redirect_pc);
    end else if (do_push) begin
      fetch_pc_next = fetch_pc_reg + INSTR_BYTES;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_reg <= align_pc(RESET_PC);
    end else begin
      fetch_pc_reg <= fetch_pc_next;
    end
  end

  assign a_instr = fetch_pc_reg;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (do_push),
    .pop   (do_pop),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_valid = (fifo_count != '0);

  // An empty queue presents a harmless NOP so decode never sees stale data.
  always_comb begin
    out_instr = NOP_INSTR;
    out_pc    = '0;
    if (!fifo_empty) begin
      out_instr = head_entry.instr;
      out_pc    = head_entry.pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios with literal
// expectations, then random traffic against a queue-based reference model.
module tb_instr_fetch;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a_instr;
  logic [31:0] rd_instr;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  int n_cmp  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] m_pc;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .a_instr        (a_instr),
    .rd_instr       (rd_instr),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
  );

  // Memory image: the word at byte address k*4 is 32'h1000_0000 + k.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign rd_instr = mem_word(a_instr);

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_pc = 32'h0000_0000;
  endfunction

  // One clock edge of the specified behaviour, using the inputs held at the edge.
  function automatic void model_clock();
    bit pop, push;
    if (rst) return;
    pop  = (mq.size() != 0) && out_ready && !redirect_valid;
    push = fetch_en && !redirect_valid && ((mq.size() < DEPTH) || pop);
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc & 32'hFFFF_FFFC;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{pc: m_pc, instr: mem_word(m_pc)});
        m_pc = m_pc + 32'd4;
      end
    end
  endfunction

  // Single compare process: every falling edge, DUT outputs versus the model.
  always @(negedge clk) begin
    if (check_en) begin
      check("a_instr", a_instr, m_pc);
      check("out_valid", {31'b0, out_valid}, {31'b0, mq.size() != 0});
      check("out_pc", out_pc, (mq.size() != 0) ? mq[0].pc : 32'h0);
      check("out_instr", out_instr, (mq.size() != 0) ? mq[0].instr : 32'h0000_0013);
      $display("cyc t=%0t a=%h v=%0d pc=%h instr=%h", $time, a_instr, out_valid, out_pc, out_instr);
    end
  end

  task automatic step();
    @(posedge clk);
    model_clock();
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    model_reset();
    check_en = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state.
    check("rst_a_instr", a_instr, 32'h0);
    check("rst_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_instr", out_instr, 32'h0000_0013);
    check("rst_out_pc", out_pc, 32'h0);

    // Streaming with out_ready high: one instruction per cycle, no gaps.
    fetch_en  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("stream_valid", {31'b0, out_valid}, 32'h1);
      check("stream_pc", out_pc, 32'(k * 4));
      check("stream_instr", out_instr, 32'h1000_0000 + 32'(k));
    end

    // Backpressure: queue fills at four entries and the PC parks at 0x10.
    do_reset();
    out_ready = 1'b0;
    repeat (8) step();
    check("bp_a_instr", a_instr, 32'h10);
    check("bp_head_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_deliver_pc", out_pc, 32'(i * 4));
      step();
    end
    // Queue now holds 14,18,1C,20 and fetch PC is 24.
    out_ready = 1'b0;
    step();
    check("full_hold_a", a_instr, 32'h24);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("full_pp_a", a_instr, 32'h28);
    check("full_pp_head", out_pc, 32'h18);
    step();
    check("full_still_full", a_instr, 32'h28);

    // Redirect while the head is valid and offered to decode.
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    step();
    redirect_valid = 1'b0;
    check("redir_valid", {31'b0, out_valid}, 32'h0);
    check("redir_a_instr", a_instr, 32'h100);
    step();
    check("redir_first_pc", out_pc, 32'h100);
    check("redir_first_instr", out_instr, 32'h1000_0040);

    // PC wrap across 2^32.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    step();
    check("wrap_pc0", out_pc, 32'hFFFF_FFF8);
    step();
    check("wrap_pc1", out_pc, 32'hFFFF_FFFC);
    step();
    check("wrap_pc2", out_pc, 32'h0000_0000);
    step();
    check("wrap_pc3", out_pc, 32'h0000_0004);

    // Asynchronous reset between edges, then fetch_en low.
    rst = 1'b1;
    model_reset();
    #1;
    check("async_valid", {31'b0, out_valid}, 32'h0);
    check("async_a_instr", a_instr, 32'h0);
    fetch_en = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    check("fe0_a_instr", a_instr, 32'h0);
    check("fe0_valid", {31'b0, out_valid}, 32'h0);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      fetch_en       = ($urandom_range(0, 9) < 8);
      out_ready      = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                   : $urandom;
      rst = ($urandom_range(0, 299) == 0);
      if (rst) model_reset();
      step();
    end
    rst = 1'b0;
    step();
    check_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
